// File: rtl/ph_input_conditioner_pkg.sv
// Default sizing for the board input conditioner, plus the idle raw level
// of a button pad for a given polarity.
package io_input_pkg;
  localparam int NUM_SW_DEF   = 32;
  localparam int NUM_BTN_DEF  = 4;
  localparam int TICK_DIV_DEF = 50000;
  localparam int DB_TICKS_DEF = 10;

  function automatic logic btn_idle(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction
endpackage

// File: rtl/ph_input_conditioner_debounce_ch.sv
// One push-button channel: 2-flop sync, polarity fix, tick-based debounce,
// press pulse and software-clearable sticky flag.
module debounce_ch
  import io_input_pkg::*;
#(
  parameter int DB_TICKS       = DB_TICKS_DEF,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_raw,
  input  logic i_clr,
  output logic o_level,
  output logic o_press,
  output logic o_latched
);
  localparam int CW = $clog2(DB_TICKS) + 1;
  localparam logic IDLE = btn_idle(BTN_ACTIVE_LOW);

  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_stable, r_prev, r_press, r_latched;
  logic          w_pressed;

  assign w_pressed = BTN_ACTIVE_LOW ? ~r_sync2 : r_sync2;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= IDLE;
      r_sync2 <= IDLE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stable state flips only after DB_TICKS consecutive differing samples.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (i_tick) begin
      if (w_pressed == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_TICKS - 1)) begin
        r_stable <= w_pressed;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Press pulse lands the cycle after the level rises; set beats clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prev    <= 1'b0;
      r_press   <= 1'b0;
      r_latched <= 1'b0;
    end else begin
      r_prev  <= r_stable;
      r_press <= r_stable & ~r_prev;
      if (r_press)    r_latched <= 1'b1;
      else if (i_clr) r_latched <= 1'b0;
    end
  end

  assign o_level   = r_stable;
  assign o_press   = r_press;
  assign o_latched = r_latched;
endmodule

// File: rtl/ph_input_conditioner.sv
// Board input conditioner: shared debounce prescaler, per-bit switch
// majority filter, and one debounce_ch per push button.
module ph_input_conditioner
  import io_input_pkg::*;
#(
  parameter int NUM_SW         = NUM_SW_DEF,
  parameter int NUM_BTN        = NUM_BTN_DEF,
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int DB_TICKS       = DB_TICKS_DEF,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_SW-1:0]  i_sw_raw,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  input  logic [NUM_BTN-1:0] i_btn_clr,
  output logic [NUM_SW-1:0]  o_io_sw,
  output logic [NUM_BTN-1:0] o_ph_button,
  output logic [NUM_BTN-1:0] o_btn_press,
  output logic [NUM_BTN-1:0] o_btn_latched
);
  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]     r_presc;
  logic              w_tick;
  logic [NUM_SW-1:0] r_sw_sync1, r_sw_sync2;
  logic [NUM_SW-1:0] r_hist0, r_hist1, r_hist2;
  logic [NUM_SW-1:0] r_sw;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Switch history advances once per tick; the output is a 2-of-3 vote.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
      r_hist0    <= '0;
      r_hist1    <= '0;
      r_hist2    <= '0;
      r_sw       <= '0;
    end else begin
      r_sw_sync1 <= i_sw_raw;
      r_sw_sync2 <= r_sw_sync1;
      if (w_tick) begin
        r_hist0 <= r_sw_sync2;
        r_hist1 <= r_hist0;
        r_hist2 <= r_hist1;
      end
      r_sw <= (r_hist0 & r_hist1) | (r_hist0 & r_hist2) | (r_hist1 & r_hist2);
    end
  end

  assign o_io_sw = r_sw;

  generate
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      debounce_ch #(
        .DB_TICKS       (DB_TICKS),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
      ) u_ch (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_tick    (w_tick),
        .i_raw     (i_btn_raw[g]),
        .i_clr     (i_btn_clr[g]),
        .o_level   (o_ph_button[g]),
        .o_press   (o_btn_press[g]),
        .o_latched (o_btn_latched[g])
      );
    end
  endgenerate
endmodule

// File: tb/tb_ph_input_conditioner.sv
// Directed bench for ph_input_conditioner at TICK_DIV=4, DB_TICKS=3, active-low buttons.
module tb_ph_input_conditioner;
  logic        clk, rst;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw, btn_clr;
  logic [31:0] io_sw;
  logic [3:0]  ph_button, btn_press, btn_latched;

  int n_vec = 0;
  int n_err = 0;
  int np, n;
  bit found, seen_lvl, seen_pls;
  logic [31:0] sw_hold;

  ph_input_conditioner #(
    .NUM_SW(32), .NUM_BTN(4), .TICK_DIV(4), .DB_TICKS(3), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_sw_raw      (sw_raw),
    .i_btn_raw     (btn_raw),
    .i_btn_clr     (btn_clr),
    .o_io_sw       (io_sw),
    .o_ph_button   (ph_button),
    .o_btn_press   (btn_press),
    .o_btn_latched (btn_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic watch1(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen_lvl |= ph_button[1];
      seen_pls |= btn_press[1];
    end
  endtask

  initial begin
    rst = 1'b1; btn_raw = 4'hF; sw_raw = 32'hFFFF_FFFF; btn_clr = 4'h0;
    // Reset holds everything at zero even with switches high
    repeat (3) @(negedge clk);
    chk("rst_sw", io_sw, 32'h0);
    chk("rst_btn", {28'h0, ph_button}, 32'h0);
    chk("rst_press", {28'h0, btn_press}, 32'h0);
    chk("rst_latch", {28'h0, btn_latched}, 32'h0);
    sw_raw = 32'h0;
    rst = 1'b0;
    np = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (btn_press != 4'h0) np++;
    end
    chk("rst_nopulse", np, 0);
    chk("idle_btn", {28'h0, ph_button}, 32'h0);

    // Clean press on button 0
    btn_raw[0] = 1'b0;
    n = 0; found = 0;
    while (!found && n < 30) begin
      @(negedge clk);
      n++;
      if (ph_button[0]) found = 1;
    end
    chk("press_window", {31'h0, found && n >= 11 && n <= 15}, 32'h1);
    np = btn_press[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      np += btn_press[0];
    end
    chk("press_once", np, 1);
    chk("latched0", {28'h0, btn_latched}, 32'h1);

    // Bounce on button 1 never reaches DB_TICKS differing samples
    seen_lvl = 0; seen_pls = 0;
    btn_raw[1] = 1'b0; watch1(3);
    btn_raw[1] = 1'b1; watch1(5);
    btn_raw[1] = 1'b0; watch1(3);
    btn_raw[1] = 1'b1; watch1(30);
    chk("bounce_level", {31'h0, seen_lvl}, 32'h0);
    chk("bounce_pulse", {31'h0, seen_pls}, 32'h0);

    // Sticky flag clear and set-beats-clear race on button 2
    btn_raw[2] = 1'b0;
    n = 0;
    while (!btn_latched[2] && n < 40) begin @(negedge clk); n++; end
    chk("lat2_set", {28'h0, btn_latched}, 32'h5);
    btn_raw[2] = 1'b1;
    repeat (25) @(negedge clk);
    btn_clr[2] = 1'b1;
    @(negedge clk);
    btn_clr[2] = 1'b0;
    chk("clr2", {28'h0, btn_latched}, 32'h1);
    btn_raw[2] = 1'b0;
    n = 0;
    while (!btn_press[2] && n < 40) begin @(negedge clk); n++; end
    chk("press2_seen", {31'h0, btn_press[2]}, 32'h1);
    btn_clr[2] = 1'b1;
    @(negedge clk);
    btn_clr[2] = 1'b0;
    chk("clr_race", {31'h0, btn_latched[2]}, 32'h1);

    // Switch filter
    sw_raw = 32'hA5A5_0F0F;
    repeat (16) @(negedge clk);
    chk("sw_pat1", io_sw, 32'hA5A5_0F0F);
    repeat (10) @(negedge clk);
    sw_raw = 32'h0;
    @(negedge clk);
    sw_raw = 32'hA5A5_0F0F;
    np = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (io_sw != 32'hA5A5_0F0F) np++;
    end
    chk("sw_glitch", np, 0);
    sw_raw = 32'h1234_5678;
    repeat (16) @(negedge clk);
    chk("sw_pat2", io_sw, 32'h1234_5678);

    // Releases never pulse
    btn_raw = 4'hF;
    np = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (btn_press != 4'h0) np++;
    end
    chk("release_nopulse", np, 0);
    chk("release_level", {28'h0, ph_button}, 32'h0);
    chk("latch_hold", {28'h0, btn_latched}, 32'h5);

    // Reset in the middle of button 3's debounce
    btn_raw[3] = 1'b0;
    n = 0;
    while (dut.g_btn[3].u_ch.r_cnt != 2 && n < 40) begin @(negedge clk); n++; end
    chk("cnt3_reached", {31'h0, dut.g_btn[3].u_ch.r_cnt == 2}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sw", io_sw, 32'h0);
    chk("mid_rst_btn", {28'h0, ph_button}, 32'h0);
    chk("mid_rst_latch", {28'h0, btn_latched}, 32'h0);
    chk("mid_rst_cnt3", {30'h0, dut.g_btn[3].u_ch.r_cnt}, 32'h0);
    chk("mid_rst_presc", {30'h0, dut.r_presc}, 32'h0);
    @(negedge clk);
    btn_raw = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    np = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (btn_press != 4'h0 || ph_button != 4'h0) np++;
    end
    chk("post_rst_quiet", np, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ph_input_conditioner.md
Name: ph_input_conditioner

Overview:
- Conditions the physical inputs (slide switches, push buttons) before they reach the core's memory-mapped input registers. This is the input-direction counterpart of the LSU output path.
- Synchronizes asynchronous pad signals into the i_clk domain, debounces them, and normalizes button polarity.
- Generates one-cycle press pulses and software-clearable sticky press flags.
- Sits between the board pins and the singlecycle top-level i_io_sw / i_ph_button inputs.

Parameters:
- NUM_SW, 32, number of slide-switch inputs.
- NUM_BTN, 4, number of push buttons.
- TICK_DIV, 50000, i_clk cycles per debounce sample tick (1 ms at 50 MHz); must be ≥ 2.
- DB_TICKS, 10, consecutive differing ticks required before a button changes state; must be ≥ 1.
- BTN_ACTIVE_LOW, 1, 1 means a raw button reads 0 when pressed.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_sw_raw  in  NUM_SW  raw switch pads, asynchronous.
- i_btn_raw  in  NUM_BTN  raw button pads, asynchronous.
- i_btn_clr  in  NUM_BTN  per-bit clear of the sticky flags, one-cycle strobe driven by the LSU write decode.
- o_io_sw  out  NUM_SW  debounced switch levels.
- o_ph_button  out  NUM_BTN  debounced button levels, normalized so 1 = pressed.
- o_btn_press  out  NUM_BTN  one-cycle pulse per debounced press.
- o_btn_latched  out  NUM_BTN  sticky press flags.

Behaviour:
- Reset: one clock (i_clk); asynchronous, active-high reset (i_reset). While i_reset is high, or after it is asserted mid-operation, every flop clears immediately:
  - o_io_sw = 0, o_ph_button = 0, o_btn_press = 0, o_btn_latched = 0.
  - Prescaler = 0, all debounce counters = 0.
  - Button sync flops = inactive raw level (1 if BTN_ACTIVE_LOW, else 0); switch sync flops = 0.
  - No spurious press pulse may follow reset release.
- Synchronizer: 2-flop synchronizer on every raw bit. Polarity normalization happens after the synchronizer: pressed = BTN_ACTIVE_LOW ? ~sync : sync.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. tick = 1 for exactly one cycle when count == TICK_DIV-1.
- Button debounce, per channel, evaluated only on tick cycles:
  - Sample equals stable state: counter cleared to 0.
  - Sample differs and counter < DB_TICKS-1: counter increments.
  - Sample differs and counter == DB_TICKS-1: stable state takes the sample and counter clears to 0.
  - Net effect: DB_TICKS consecutive differing ticks are needed for a change; a glitch shorter than one tick interval never changes the state.
  - On non-tick cycles the counter holds.
- Switch filter, per bit, on each tick:
  - Shift the synchronized value into a 3-deep sample history.
  - o_io_sw bit is registered as the majority of the 3 samples.
  - Switches have no press pulses.
- o_btn_press[i]: high for exactly one cycle, the cycle after o_ph_button[i] goes 0→1. A release (1→0) produces no pulse.
- o_btn_latched[i]:
  - Set when o_btn_press[i] is high; cleared when i_btn_clr[i] is high.
  - Set and clear in the same cycle: set wins, so no press is lost.
  - Otherwise the flag holds.
- Latency, raw edge to o_ph_button: from 2 + (DB_TICKS-1)*TICK_DIV + 1 cycles to 2 + DB_TICKS*TICK_DIV + 1 cycles.
- Width rules:
  - Prescaler width = $clog2(TICK_DIV).
  - Debounce counter width = $clog2(DB_TICKS) + 1, which is never zero-width.
  - Compares are done at counter width; no overflow is possible.

Decomposition:
- Package io_input_pkg holds default constants: NUM_SW_DEF = 32, NUM_BTN_DEF = 4, TICK_DIV_DEF = 50000, DB_TICKS_DEF = 10.
- One sub-module, debounce_ch: a single button channel with sync, counter, stable state, press pulse and sticky flag. Its inputs are i_clk, i_reset, tick, raw, clr.
- Instantiate debounce_ch NUM_BTN times in a generate loop. The switch filter and the prescaler stay in the top of the block.

Test Plan (TICK_DIV=4, DB_TICKS=3, BTN_ACTIVE_LOW=1 unless stated):
1. Reset: hold i_reset with i_btn_raw=4'b1111 and i_sw_raw=32'hFFFF_FFFF → all outputs 0 during reset. Release with buttons idle → o_btn_press stays 0 for 50 cycles.
2. Clean press: drive i_btn_raw[0] 1→0 and hold → o_ph_button[0] rises within cycles 11..15 after the edge. o_btn_press[0] is high for exactly 1 cycle. o_btn_latched = 4'b0001.
3. Bounce: toggle i_btn_raw[1] low for 3 cycles, high for 5, low for 3, then high → o_ph_button[1] never asserts and no pulse occurs.
4. Clear race: with o_btn_latched[2] = 1, pulse i_btn_clr[2] → flag goes to 0 next cycle. Re-press button 2 and assert i_btn_clr[2] in the same cycle as o_btn_press[2] → flag reads 1.
5. Switches: set i_sw_raw = 32'hA5A5_0F0F → o_io_sw = 32'hA5A5_0F0F within 2+3*4+2 cycles. A single-cycle glitch to 32'h0 between ticks leaves o_io_sw unchanged.
6. Reset mid-debounce: assert i_reset while button 3's counter = 2 → all outputs and counters are 0 immediately. After release with the button idle, no pulse occurs.
